// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types, constants and baud divisor helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_START = 3'b001,
        ST_DATA  = 3'b011,
        ST_STOP  = 3'b010,
        ST_BREAK = 3'b110
    } t_uartrxonly_state;

    localparam int c_uart_oversample = 16;
    localparam int c_uart_data_bits  = 8;

    // 7.3728 MHz / (16 * baud) == 4 * 115200 / baud
    function automatic int f_ce_divisor(input int baud);
        return (4 * 115200) / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_only_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_only_if
//  Description : Received-byte output bundle of the RX-only UART.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_only_if;

    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       o_rx_frame_err;

    modport master (
        output o_rx_data,
        output o_rx_valid,
        output o_rx_frame_err
    );

    modport slave (
        input o_rx_data,
        input o_rx_valid,
        input o_rx_frame_err
    );

endinterface
`default_nettype wire

// File: rtl/clock_enable_divider.sv
`default_nettype none
// ============================================================================
//  Module      : clock_enable_divider
//  Description : Single-cycle clock-enable pulse every par_ce_divisor
//                qualified input enables.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_enable_divider #(
    parameter int par_ce_divisor = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_ce_mhz,
    output logic      o_ce
);

    localparam int c_cnt_w = (par_ce_divisor > 1) ? $clog2(par_ce_divisor) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(par_ce_divisor - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_ce;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_ce  <= 1'b0;
        end else begin
            r_ce <= 1'b0;
            if (i_ce_mhz) begin
                if (r_cnt == c_cnt_last) begin
                    r_cnt <= '0;
                    r_ce  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_ce = r_ce;

endmodule
`default_nettype wire

// File: rtl/uart_rx_only.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_only
//  Description : 16x-oversampling 8N1 UART receiver with frame-error and
//                break handling; one-cycle valid / frame-error pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_only
    import uart_pkg::*;
#(
    parameter int parm_BAUD        = 115200,
    parameter int parm_sync_stages = 2
) (
    input  wire logic          i_clk_7_37mhz,
    input  wire logic          i_rst_7_37mhz,
    input  wire logic          ei_uart_rx,
    uart_rx_only_if.master     rx_bus
);

    localparam int         c_ce_divisor = f_ce_divisor(parm_BAUD);
    localparam logic [3:0] c_mid_start  = 4'(c_uart_oversample / 2 - 1);
    localparam logic [3:0] c_last_tick  = 4'(c_uart_oversample - 1);
    localparam logic [2:0] c_last_bit   = 3'(c_uart_data_bits - 1);

    logic                          w_tick;
    logic [parm_sync_stages-1:0]   r_sync;
    logic                          w_rx_s;

    t_uartrxonly_state             r_state;
    t_uartrxonly_state             w_next;

    logic [3:0]                    r_s_t;
    logic [2:0]                    r_s_i;
    logic [c_uart_data_bits-1:0]   r_shift;
    logic [7:0]                    r_rx_data;
    logic                          r_rx_valid;
    logic                          r_rx_frame_err;

    logic                          w_shift_en;
    logic                          w_stop_mid;
    logic                          w_byte_ok;
    logic                          w_frame_bad;
    logic                          w_clr_t;

    clock_enable_divider #(
        .par_ce_divisor (c_ce_divisor)
    ) u_ce_div (
        .clk      (i_clk_7_37mhz),
        .rst      (i_rst_7_37mhz),
        .i_ce_mhz (1'b1),
        .o_ce     (w_tick)
    );

    // Synchronizer resets high so a reset never looks like a start bit
    always_ff @(posedge i_clk_7_37mhz) begin
        if (i_rst_7_37mhz) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[parm_sync_stages-2:0], ei_uart_rx};
        end
    end

    assign w_rx_s = r_sync[parm_sync_stages-1];

    always_ff @(posedge i_clk_7_37mhz) begin
        if (i_rst_7_37mhz) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_tick && !w_rx_s) w_next = ST_START;
            end
            ST_START: begin
                if (w_tick && (r_s_t == c_mid_start)) w_next = w_rx_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_tick && (r_s_t == c_last_tick) && (r_s_i == c_last_bit)) w_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_tick && (r_s_t == c_last_tick)) w_next = w_rx_s ? ST_IDLE : ST_BREAK;
            end
            ST_BREAK: begin
                if (w_tick && w_rx_s) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_shift_en  = w_tick && (r_state == ST_DATA) && (r_s_t == c_last_tick);
        w_stop_mid  = w_tick && (r_state == ST_STOP) && (r_s_t == c_last_tick);
        w_byte_ok   = w_stop_mid && w_rx_s;
        w_frame_bad = w_stop_mid && !w_rx_s;
        w_clr_t     = (w_next != r_state) || (r_state == ST_IDLE) || (r_state == ST_BREAK);
    end

    // Pulses are cleared every clock; everything else advances only on ticks
    always_ff @(posedge i_clk_7_37mhz) begin
        if (i_rst_7_37mhz) begin
            r_s_t          <= 4'd0;
            r_s_i          <= 3'd0;
            r_shift        <= '0;
            r_rx_data      <= 8'h00;
            r_rx_valid     <= 1'b0;
            r_rx_frame_err <= 1'b0;
        end else begin
            r_rx_valid     <= w_byte_ok;
            r_rx_frame_err <= w_frame_bad;
            if (w_byte_ok) begin
                r_rx_data <= r_shift;
            end
            if (w_tick) begin
                r_s_t <= w_clr_t ? 4'd0 : r_s_t + 4'd1;
                if (r_state == ST_START) begin
                    r_s_i <= 3'd0;
                end else if (w_shift_en) begin
                    r_shift <= {w_rx_s, r_shift[c_uart_data_bits-1:1]};
                    r_s_i   <= r_s_i + 3'd1;
                end
            end
        end
    end

    assign rx_bus.o_rx_data      = r_rx_data;
    assign rx_bus.o_rx_valid     = r_rx_valid;
    assign rx_bus.o_rx_frame_err = r_rx_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_only.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_only
//  Description : Self-checking bench for uart_rx_only at 115200 and 9600 baud.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_only;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst_a, rst_b;
    logic line_a, line_b;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses_a = 0;

    exp_t       qa[$];
    exp_t       qb[$];
    logic [7:0] last_data [2];
    logic       prev_v_a = 1'b0, prev_e_a = 1'b0, prev_v_b = 1'b0, prev_e_b = 1'b0;

    uart_rx_only_if bus_a ();
    uart_rx_only_if bus_b ();

    uart_rx_only #(.parm_BAUD(115200), .parm_sync_stages(2)) dut_a (
        .i_clk_7_37mhz (clk),
        .i_rst_7_37mhz (rst_a),
        .ei_uart_rx    (line_a),
        .rx_bus        (bus_a)
    );

    uart_rx_only #(.parm_BAUD(9600), .parm_sync_stages(2)) dut_b (
        .i_clk_7_37mhz (clk),
        .i_rst_7_37mhz (rst_b),
        .ei_uart_rx    (line_b),
        .rx_bus        (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input int w, input logic v);
        if (w == 0) line_a = v;
        else        line_b = v;
    endtask

    // One 8N1 frame; the model records what the receiver must report for it
    task automatic send_frame(input int w, input logic [7:0] b, input int cpb,
                              input logic stop, input bit expect_it);
        exp_t it;
        it.err  = ~stop;
        it.data = b;
        if (expect_it) begin
            if (w == 0) qa.push_back(it);
            else        qb.push_back(it);
        end
        drive(w, 1'b0);
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(w, b[i]);
            repeat (cpb) @(negedge clk);
        end
        drive(w, stop);
        repeat (cpb) @(negedge clk);
    endtask

    task automatic observe(input int w, input logic v, input logic e, input logic [7:0] d,
                           input logic pv, input logic pe);
        exp_t it;
        int   sz;
        check("pulse_exclusive", 32'(v & e), 0);
        check("pulse_width", 32'(pv | pe), 0);
        sz = (w == 0) ? qa.size() : qb.size();
        if (sz == 0) begin
            check("unexpected_pulse", 32'(sz), 1);
        end else begin
            it = (w == 0) ? qa.pop_front() : qb.pop_front();
            check("pulse_kind", 32'(e), 32'(it.err));
            if (it.err) begin
                check("data_held", 32'(d), 32'(last_data[w]));
            end else begin
                check("rx_data", 32'(d), 32'(it.data));
                last_data[w] = it.data;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_a && (bus_a.o_rx_valid || bus_a.o_rx_frame_err)) begin
            pulses_a++;
            observe(0, bus_a.o_rx_valid, bus_a.o_rx_frame_err, bus_a.o_rx_data, prev_v_a, prev_e_a);
        end
        if (!rst_b && (bus_b.o_rx_valid || bus_b.o_rx_frame_err)) begin
            observe(1, bus_b.o_rx_valid, bus_b.o_rx_frame_err, bus_b.o_rx_data, prev_v_b, prev_e_b);
        end
        prev_v_a <= bus_a.o_rx_valid;
        prev_e_a <= bus_a.o_rx_frame_err;
        prev_v_b <= bus_b.o_rx_valid;
        prev_e_b <= bus_b.o_rx_frame_err;
    end

    task automatic wait_drain(input int w, input string tag);
        int n = 0;
        while (((w == 0) ? qa.size() : qb.size()) != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'((w == 0) ? qa.size() : qb.size()), 0);
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        logic [7:0] rb;
        line_a = 1'b1;
        line_b = 1'b1;
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        last_data[0] = 8'h00;
        last_data[1] = 8'h00;
        repeat (4) @(negedge clk);
        check("rst_data_a",  32'(bus_a.o_rx_data), 0);
        check("rst_valid_a", 32'(bus_a.o_rx_valid), 0);
        check("rst_err_a",   32'(bus_a.o_rx_frame_err), 0);
        check("rst_data_b",  32'(bus_b.o_rx_data), 0);
        check("rst_valid_b", 32'(bus_b.o_rx_valid), 0);
        check("rst_err_b",   32'(bus_b.o_rx_frame_err), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (100) @(negedge clk);

        fork
            begin : thread_a
                send_frame(0, 8'hA5, 64, 1'b1, 1'b1);
                wait_drain(0, "drain_a5");
                repeat (64) @(negedge clk);

                send_frame(0, 8'h55, 64, 1'b1, 1'b1);
                send_frame(0, 8'h00, 64, 1'b1, 1'b1);
                send_frame(0, 8'hFF, 64, 1'b1, 1'b1);
                wait_drain(0, "drain_b2b");
                repeat (64) @(negedge clk);

                p0 = pulses_a;
                line_a = 1'b0;
                repeat (20) @(negedge clk);
                line_a = 1'b1;
                repeat (1000) @(negedge clk);
                check("glitch_quiet", 32'(pulses_a - p0), 0);

                send_frame(0, 8'h3C, 64, 1'b0, 1'b1);
                repeat (2000) @(negedge clk);
                line_a = 1'b1;
                repeat (128) @(negedge clk);
                check("break_one_err", 32'(pulses_a - p0), 1);
                send_frame(0, 8'h81, 64, 1'b1, 1'b1);
                wait_drain(0, "drain_81");
                repeat (64) @(negedge clk);

                // Reset lands in bit 6 of C3; remaining bits and stop are high
                fork
                    send_frame(0, 8'hC3, 64, 1'b1, 1'b0);
                    begin
                        repeat (7 * 64 + 32) @(negedge clk);
                        rst_a = 1'b1;
                        @(negedge clk);
                        rst_a = 1'b0;
                        last_data[0] = 8'h00;
                        check("abort_data",  32'(bus_a.o_rx_data), 0);
                        check("abort_valid", 32'(bus_a.o_rx_valid), 0);
                        check("abort_err",   32'(bus_a.o_rx_frame_err), 0);
                    end
                join
                repeat (200) @(negedge clk);
                check("abort_quiet", 32'(qa.size()), 0);
                send_frame(0, 8'h12, 64, 1'b1, 1'b1);
                wait_drain(0, "drain_12");

                for (int k = 0; k < 30; k++) begin
                    rb = 8'($urandom_range(0, 255));
                    if ($urandom_range(0, 7) == 0) begin
                        send_frame(0, rb, 64, 1'b0, 1'b1);
                        line_a = 1'b0;
                        repeat ($urandom_range(0, 200)) @(negedge clk);
                        line_a = 1'b1;
                        repeat (64) @(negedge clk);
                    end else begin
                        send_frame(0, rb, 64, 1'b1, 1'b1);
                        repeat ($urandom_range(0, 2) * 64) @(negedge clk);
                    end
                end
                wait_drain(0, "drain_rand_a");
            end
            begin : thread_b
                send_frame(1, 8'h6E, 753, 1'b1, 1'b1);
                wait_drain(1, "drain_6e_fast");
                send_frame(1, 8'h6E, 783, 1'b1, 1'b1);
                wait_drain(1, "drain_6e_slow");
                send_frame(1, 8'($urandom_range(0, 255)), 768, 1'b1, 1'b1);
                wait_drain(1, "drain_rand_b");
            end
        join

        repeat (200) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
